// File: rtl/data_memory_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
interface data_memory_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata,
        input  busy, ack, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output busy, ack, rdata, err
    );
endinterface

// File: rtl/data_memory_responder.sv
// Fixed-latency word memory answering MEM-stage loads/stores: stalls while an access is
// outstanding, then pulses ack with registered read data and error flag.
module data_memory_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    data_memory_responder_if.slave  bus
);
    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
    localparam int unsigned CntW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       mem_q [DEPTH_WORDS];

    logic              enter_done;
    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic              acc_err;
    logic [IdxW-1:0]   acc_idx;
    logic              mem_we;

    // With LATENCY=1 the access happens on the accepting edge, so use the live inputs.
    always_comb begin
        acc_we    = (state_q == StIdle) ? bus.we    : we_q;
        acc_addr  = (state_q == StIdle) ? bus.addr  : addr_q;
        acc_wdata = (state_q == StIdle) ? bus.wdata : wdata_q;
        acc_idx   = acc_addr[IdxW+1:2];
        acc_err   = (acc_addr[1:0] != 2'b00) || ((acc_addr >> 2) >= 32'(DEPTH_WORDS));
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        enter_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    if (LATENCY == 1) begin
                        state_d    = StDone;
                        enter_done = 1'b1;
                    end else begin
                        cnt_d   = CntW'(LATENCY - 2);
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d    = StDone;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (enter_done) begin
            ack_d = 1'b1;
            if (acc_err) begin
                err_d   = 1'b1;
                rdata_d = '0;
            end else if (!acc_we) begin
                rdata_d = mem_q[acc_idx];
            end
        end
    end

    assign mem_we = enter_done && acc_we && !acc_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is not reset; the guard keeps a write from landing while reset is held.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign bus.busy  = (state_q == StBusy) || ((state_q == StIdle) && bus.req);
    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
endmodule
